// File: rtl/tone_gen_src.sv
// tone_gen_src: burst tone source feeding a filter input through a
// valid/ready handshake. A 16-step phase counter drives sine (quarter-wave
// table), square, impulse or silence, attenuated by a right shift of 0..3.
// Optional feature: define TONE_GEN_IMPULSE_EN to build the impulse
// generator; without it mode 10 produces silence like mode 11.
module tone_gen_src #(
  parameter int NUM_PERIODS = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_en,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  mode,
  input  logic [1:0]  amp_shift,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        busy,
  output logic        period_done,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  phase_reg;
  logic [7:0]  period_cnt_reg;
  logic [1:0]  mode_reg;
  logic [1:0]  amp_reg;
  logic        stop_pend_reg;
  logic [15:0] sample_reg;
  logic        valid_reg;
  logic        period_done_reg;
  logic        overrun_reg;
`ifdef TONE_GEN_IMPULSE_EN
  logic        first_reg;
`endif

  logic        start_ok;
  logic        capture;
  logic        accept;
  logic        last_period;
  logic        finish;
  logic [15:0] sample_next;

  // Handshake and burst control events shared by the FSM and datapath.
  assign start_ok    = (state_reg == IDLE) && start && !stop;
  assign capture     = (state_reg == ARM) && sample_en && !stop;
  assign accept      = (state_reg == PRESENT) && valid_reg && sample_ready;
  assign last_period = (NUM_PERIODS != 0) && (phase_reg == 4'd15) &&
                       (period_cnt_reg == 8'(NUM_PERIODS - 1));
  assign finish      = accept && (stop_pend_reg || stop || last_period);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode: stop in ARM aborts at once, stop in PRESENT waits
  // for the pending sample to be taken.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = ARM;
      ARM: begin
        if (stop)           state_next = IDLE;
        else if (sample_en) state_next = PRESENT;
      end
      PRESENT: if (accept) state_next = finish ? IDLE : ARM;
      default: state_next = IDLE;
    endcase
  end

  // Waveform generation for the current phase with the captured settings.
  always_comb begin
    logic [1:0]  quad;
    logic [1:0]  idx;
    logic [2:0]  tidx;
    logic [14:0] tval;
    logic [15:0] mag;
    logic [15:0] shifted;
    logic        neg;
    quad = phase_reg[3:2];
    idx  = phase_reg[1:0];
    // Odd quadrants walk the quarter-wave table backwards.
    tidx = quad[0] ? (3'd4 - {1'b0, idx}) : {1'b0, idx};
    case (tidx)
      3'd0:    tval = 15'd0;
      3'd1:    tval = 15'd12540;
      3'd2:    tval = 15'd23170;
      3'd3:    tval = 15'd30273;
      default: tval = 15'd32767;
    endcase
    mag = 16'd0;
    neg = 1'b0;
    case (mode_reg)
      2'b00: begin
        mag = {1'b0, tval};
        neg = quad[1];
      end
      2'b01: begin
        mag = 16'd32767;
        neg = phase_reg[3];
      end
`ifdef TONE_GEN_IMPULSE_EN
      2'b10: mag = (first_reg && (phase_reg == 4'd0)) ? 16'd32767 : 16'd0;
`else
      2'b10: mag = 16'd0;
`endif
      default: mag = 16'd0;
    endcase
    // Shift the magnitude before applying the sign so peaks stay symmetric.
    shifted     = mag >> amp_reg;
    sample_next = neg ? (16'd0 - shifted) : shifted;
  end

  // Burst configuration, phase and period counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_reg       <= 2'b11;
      amp_reg        <= 2'b00;
      phase_reg      <= 4'd0;
      period_cnt_reg <= 8'd0;
      stop_pend_reg  <= 1'b0;
`ifdef TONE_GEN_IMPULSE_EN
      first_reg      <= 1'b0;
`endif
    end else begin
      if (start_ok) begin
        mode_reg       <= mode;
        amp_reg        <= amp_shift;
        phase_reg      <= 4'd0;
        period_cnt_reg <= 8'd0;
        stop_pend_reg  <= 1'b0;
`ifdef TONE_GEN_IMPULSE_EN
        first_reg      <= 1'b1;
`endif
      end
      if ((state_reg == PRESENT) && stop && !accept) begin
        stop_pend_reg <= 1'b1;
      end
      if (accept) begin
        phase_reg <= phase_reg + 4'd1;
        if (phase_reg == 4'd15) begin
          period_cnt_reg <= period_cnt_reg + 8'd1;
`ifdef TONE_GEN_IMPULSE_EN
          first_reg      <= 1'b0;
`endif
        end
      end
    end
  end

  // Output sample register: loaded on a strobe in ARM, held until taken,
  // cleared whenever the burst ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_reg <= 16'd0;
      valid_reg  <= 1'b0;
    end else begin
      if (capture) begin
        sample_reg <= sample_next;
        valid_reg  <= 1'b1;
      end
      if (accept) begin
        valid_reg <= 1'b0;
      end
      if ((state_reg != IDLE) && (state_next == IDLE)) begin
        sample_reg <= 16'd0;
        valid_reg  <= 1'b0;
      end
    end
  end

  // Status flags: period pulse and sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_done_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      period_done_reg <= accept && (phase_reg == 4'd15);
      if (start_ok) begin
        overrun_reg <= 1'b0;
      end else if ((state_reg == PRESENT) && sample_en && !accept) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign sample_out   = sample_reg;
  assign sample_valid = valid_reg;
  assign busy         = (state_reg != IDLE);
  assign period_done  = period_done_reg;
  assign overrun      = overrun_reg;

endmodule
